// File: rtl/rps_opponent.sv
// rtl/rps_opponent.sv - rock-paper-scissors computer opponent with spin/stop and scored response
//
// Purpose: takes a player move from the game controller and spins through the three moves.
// When the player's stop_signal is honoured, the spin freezes. The block then scores the
// round and returns the opponent move and the result over a valid/ready handshake.
//
// Ports:
//   clock         in   single clock, rising edge
//   reset_button  in   asynchronous active-high reset
//   req_valid     in   controller presents a player move
//   req_move[1:0] in   player move: 01 rock, 10 paper, 11 scissors, 00 invalid
//   req_ready     out  request accepted (IDLE only)
//   stop_signal   in   level, freezes the spin once the minimum shuffle has elapsed
//   resp_valid    out  result available
//   resp_ready    in   controller consumes the result
//   resp_move[1:0]   out  opponent move
//   resp_result[1:0] out  01 player wins, 10 player loses, 11 draw, 00 none
//   spin_move[1:0]   out  current spinning move, for display
//   busy          out  not IDLE

module rps_opponent #(
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    parameter int unsigned SHUFFLE_MIN = 4
) (
    input  logic       clock,
    input  logic       reset_button,
    input  logic       req_valid,
    input  logic [1:0] req_move,
    output logic       req_ready,
    input  logic       stop_signal,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [1:0] resp_move,
    output logic [1:0] resp_result,
    output logic [1:0] spin_move,
    output logic       busy
);

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [3:0] SMIN = 4'(SHUFFLE_MIN);

    localparam logic [1:0] ROCK     = 2'b01;
    localparam logic [1:0] PAPER    = 2'b10;
    localparam logic [1:0] SCISSORS = 2'b11;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_WIN  = 2'b01;
    localparam logic [1:0] RES_LOSE = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SPIN,
        S_RESOLVE,
        S_RESPOND
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [3:0] spin_cnt_q, spin_cnt_d;
    logic [1:0] spin_move_q, spin_move_d;
    logic [1:0] player_q, player_d;
    logic [1:0] opp_q, opp_d;
    logic [1:0] resp_move_q, resp_move_d;
    logic [1:0] resp_result_q, resp_result_d;

    function automatic logic [1:0] rotate(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            ROCK:    r = PAPER;
            PAPER:   r = SCISSORS;
            default: r = ROCK;
        endcase
        return r;
    endfunction

    // Two random bits fold onto three moves; 11 aliases to rock.
    function automatic logic [1:0] seed_move(input logic [1:0] b);
        return (b == 2'b11) ? ROCK : (b + 2'b01);
    endfunction

    // Moves 1..3 sit on a cycle where each beats its predecessor, so
    // (player - opp) mod 3 picks the outcome: 0 draw, 1 win, 2 lose.
    // Adding 3 first keeps the difference positive (range 1..5).
    function automatic logic [1:0] score(input logic [1:0] p, input logic [1:0] o);
        logic [2:0] d;
        logic [1:0] r;
        d = {1'b0, p} + 3'd3 - {1'b0, o};
        case (d)
            3'd3:       r = RES_DRAW;
            3'd1, 3'd4: r = RES_WIN;
            default:    r = RES_LOSE;
        endcase
        return r;
    endfunction

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running in every state.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_comb begin
        state_d       = state_q;
        spin_cnt_d    = spin_cnt_q;
        spin_move_d   = spin_move_q;
        player_d      = player_q;
        opp_d         = opp_q;
        resp_move_d   = resp_move_q;
        resp_result_d = resp_result_q;

        case (state_q)
            S_IDLE: begin
                // An invalid move still completes the handshake but is dropped.
                if (req_valid && (req_move != 2'b00)) begin
                    player_d    = req_move;
                    spin_move_d = seed_move(lfsr_q[1:0]);
                    spin_cnt_d  = 4'd0;
                    state_d     = S_SPIN;
                end
            end
            S_SPIN: begin
                if (stop_signal && (spin_cnt_q >= SMIN)) begin
                    opp_d   = spin_move_q;
                    state_d = S_RESOLVE;
                end else begin
                    spin_move_d = rotate(spin_move_q);
                    if (spin_cnt_q < SMIN) begin
                        spin_cnt_d = spin_cnt_q + 4'd1;
                    end
                end
            end
            S_RESOLVE: begin
                resp_move_d   = opp_q;
                resp_result_d = score(player_q, opp_q);
                state_d       = S_RESPOND;
            end
            S_RESPOND: begin
                if (resp_ready) begin
                    resp_result_d = RES_NONE;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset_button) begin
        if (reset_button) begin
            state_q       <= S_IDLE;
            lfsr_q        <= SEED;
            spin_cnt_q    <= 4'd0;
            spin_move_q   <= 2'b00;
            player_q      <= 2'b00;
            opp_q         <= 2'b00;
            resp_move_q   <= 2'b00;
            resp_result_q <= RES_NONE;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            spin_cnt_q    <= spin_cnt_d;
            spin_move_q   <= spin_move_d;
            player_q      <= player_d;
            opp_q         <= opp_d;
            resp_move_q   <= resp_move_d;
            resp_result_q <= resp_result_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign resp_valid  = (state_q == S_RESPOND);
    assign resp_move   = resp_move_q;
    assign resp_result = resp_result_q;
    assign spin_move   = spin_move_q;

endmodule
